// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared FIR sample widths and round/saturate helper
package fir_pkg;

    localparam int FIR_IN_W  = 12;
    localparam int FIR_ACC_W = 32;

    // One guard bit above the accumulator so the rounding add cannot wrap
    typedef logic signed [FIR_ACC_W:0] acc_ext_t;

    typedef struct packed {
        logic                 sat;
        logic [FIR_ACC_W-1:0] q;
    } sat_round_t;

    // Round-half-up by 2^shift, then clamp to a signed out_w-bit range
    function automatic sat_round_t sat_round(input logic [FIR_ACC_W-1:0] x,
                                             input int shift,
                                             input int out_w);
        acc_ext_t   t;
        acc_ext_t   q;
        acc_ext_t   max_v;
        acc_ext_t   min_v;
        sat_round_t r;
        t     = acc_ext_t'($signed(x)) + (acc_ext_t'(1) <<< (shift - 1));
        q     = t >>> shift;
        max_v = (acc_ext_t'(1) <<< (out_w - 1)) - acc_ext_t'(1);
        min_v = -max_v - acc_ext_t'(1);
        r.sat = 1'b0;
        r.q   = q[FIR_ACC_W-1:0];
        if (q > max_v) begin
            r.sat = 1'b1;
            r.q   = max_v[FIR_ACC_W-1:0];
        end else if (q < min_v) begin
            r.sat = 1'b1;
            r.q   = min_v[FIR_ACC_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// rtl/fir_sync_fifo.sv - show-ahead synchronous FIFO, power-of-two depth
module fir_sync_fifo import fir_pkg::*; #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [W-1:0]               i_push_data,
    input  logic                       i_pop,
    output logic [W-1:0]               o_head,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_level == LW'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    // A pop frees the head slot this edge, so a full FIFO still takes a push
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Storage, pointers and occupancy; pointers wrap because DEPTH is 2^AW
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/fir_requant_decim.sv
// rtl/fir_requant_decim.sv - FIR output requantise, decimate and buffer
module fir_requant_decim import fir_pkg::*; #(
    parameter int IN_W       = 32,
    parameter int OUT_W      = 16,
    parameter int SHIFT      = 12,
    parameter int DECIM      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [IN_W-1:0]               in_data,
    input  logic                          clr_flags,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_W-1:0]              out_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          sat_flag,
    output logic                          ovf_flag
);

    localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;

    logic [FIR_ACC_W-1:0] w_x;
    sat_round_t           w_sr;
    logic                 w_unused_hi;
    logic                 w_keep;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;

    logic                 r_q_valid;
    logic [OUT_W-1:0]     r_q_data;
    logic [PH_W-1:0]      r_phase;
    logic                 r_sat_flag;
    logic                 r_ovf_flag;

    assign w_x         = FIR_ACC_W'($signed(in_data));
    assign w_sr        = sat_round(w_x, SHIFT, OUT_W);
    assign w_unused_hi = ^w_sr.q[FIR_ACC_W-1:OUT_W];
    assign w_keep      = r_q_valid && (r_phase == '0);
    assign w_pop       = out_ready && !w_empty;
    assign out_valid   = !w_empty;
    assign sat_flag    = r_sat_flag;
    assign ovf_flag    = r_ovf_flag;

    // Stage 1: register the rounded and clamped sample
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_q_valid <= 1'b0;
            r_q_data  <= '0;
        end else begin
            r_q_valid <= in_valid;
            if (in_valid) begin
                r_q_data <= w_sr.q[OUT_W-1:0];
            end
        end
    end

    // Decimation phase advances only on stage-1 valid samples
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_phase <= '0;
        end else if (r_q_valid) begin
            r_phase <= (r_phase == PH_W'(DECIM - 1)) ? '0 : r_phase + PH_W'(1);
        end
    end

    // Sticky flags; a set in the same cycle as a clear takes priority
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sat_flag <= 1'b0;
            r_ovf_flag <= 1'b0;
        end else begin
            if (in_valid && w_sr.sat) begin
                r_sat_flag <= 1'b1;
            end else if (clr_flags) begin
                r_sat_flag <= 1'b0;
            end
            if (w_keep && w_full && !w_pop) begin
                r_ovf_flag <= 1'b1;
            end else if (clr_flags) begin
                r_ovf_flag <= 1'b0;
            end
        end
    end

    fir_sync_fifo #(
        .W     (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_keep),
        .i_push_data (r_q_data),
        .i_pop       (out_ready),
        .o_head      (out_data),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_level     (fifo_level)
    );

endmodule
